// File: rtl/fpu_pkg.sv
// Shared types and constants for the FP add/sub scheduler.
package fpu_pkg;

  localparam logic OP_FSUB = 1'b0;
  localparam logic OP_FADD = 1'b1;

  localparam int unsigned FP32_W        = 32;
  localparam int unsigned FP32_SIGN_BIT = 31;

  // Tag ids are sized for the largest supported requester count (8).
  localparam int unsigned IDW_MAX = 3;

  typedef struct packed {
    logic               vld;
    logic [IDW_MAX-1:0] id;
  } tag_t;

endpackage

// File: rtl/fpu_addsub_sched_if.sv
// Requester, subtract-unit and response signals of the shared FP add/sub scheduler.
interface fpu_addsub_sched_if #(
  parameter int unsigned N = 4
);
  localparam int unsigned IDW = $clog2(N);

  logic            issue_en;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_op;
  logic [N*32-1:0] req_x1;
  logic [N*32-1:0] req_x2;
  logic [N-1:0]    req_ready;
  logic [31:0]     unit_x1;
  logic [31:0]     unit_x2;
  logic [31:0]     unit_y;
  logic [N-1:0]    resp_valid;
  logic [IDW-1:0]  resp_id;
  logic [31:0]     resp_y;
  logic            busy;

  modport slave (
    input  issue_en, req_valid, req_op, req_x1, req_x2, unit_y,
    output req_ready, unit_x1, unit_x2, resp_valid, resp_id, resp_y, busy
  );

  modport master (
    output issue_en, req_valid, req_op, req_x1, req_x2, unit_y,
    input  req_ready, unit_x1, unit_x2, resp_valid, resp_id, resp_y, busy
  );
endinterface

// File: rtl/fpu_addsub_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr wins, wrapping mod N.
module rr_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_any
);

  always_comb begin
    int unsigned idx;
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr) + k) % N;
      if (!gnt_any && req[IDW'(idx)]) begin
        gnt_any = 1'b1;
        gnt     = N'(1) << idx;
        gnt_id  = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/fpu_addsub_sched.sv
// Shares one fixed-latency FP subtract unit among N requesters; a tag pipeline
// running beside the unit routes each result back to the requester that issued it.
module fpu_addsub_sched
  import fpu_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned LAT = 2
) (
  input logic               clk,
  input logic               rstn,
  fpu_addsub_sched_if.slave bus
);

  localparam int unsigned IDW = $clog2(N);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [N-1:0]   cand_c;
  logic [N-1:0]   gnt_c;
  logic [IDW-1:0] gnt_id_c;
  logic           gnt_any_c;
  logic [31:0]    x1_arr [N];
  logic [31:0]    x2_arr [N];
  logic [31:0]    unit_x1_c, unit_x2_c;
  tag_t           tags_q [LAT];
  tag_t           out_tag;
  logic           busy_c;

  // No grants in reset or while issue is disabled.
  assign cand_c = bus.req_valid & {N{bus.issue_en & rstn}};

  rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
    .req     (cand_c),
    .ptr     (ptr_q),
    .gnt     (gnt_c),
    .gnt_id  (gnt_id_c),
    .gnt_any (gnt_any_c)
  );

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign x1_arr[i] = bus.req_x1[32*i +: 32];
    assign x2_arr[i] = bus.req_x2[32*i +: 32];
  end

  // Unit computes x1 - x2, so FADD issues with x2's sign flipped.
  always_comb begin
    unit_x1_c = '0;
    unit_x2_c = '0;
    if (gnt_any_c) begin
      unit_x1_c = x1_arr[gnt_id_c];
      unit_x2_c = x2_arr[gnt_id_c];
      unit_x2_c[FP32_SIGN_BIT] = x2_arr[gnt_id_c][FP32_SIGN_BIT] ^ bus.req_op[gnt_id_c];
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any_c) begin
      if (32'(gnt_id_c) == N - 1) ptr_d = '0;
      else                        ptr_d = gnt_id_c + IDW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q <= '0;
      for (int k = 0; k < LAT; k++) tags_q[k] <= '0;
    end else begin
      ptr_q     <= ptr_d;
      tags_q[0] <= '{vld: gnt_any_c, id: IDW_MAX'(gnt_id_c)};
      for (int k = 1; k < LAT; k++) tags_q[k] <= tags_q[k-1];
    end
  end

  always_comb begin
    busy_c = 1'b0;
    for (int k = 0; k < LAT; k++) busy_c = busy_c | tags_q[k].vld;
  end

  assign out_tag        = tags_q[LAT-1];
  assign bus.req_ready  = gnt_c;
  assign bus.unit_x1    = unit_x1_c;
  assign bus.unit_x2    = unit_x2_c;
  assign bus.resp_valid = out_tag.vld ? (N'(1) << out_tag.id) : '0;
  assign bus.resp_id    = IDW'(out_tag.id);
  assign bus.resp_y     = bus.unit_y;
  assign bus.busy       = busy_c;

endmodule

// File: tb/tb_fpu_addsub_sched.sv
// Self-checking bench for fpu_addsub_sched with a real-arithmetic subtract unit model.
module tb_fpu_addsub_sched;

  localparam int N   = 4;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  fpu_addsub_sched_if #(.N(N)) bus ();

  fpu_addsub_sched #(.N(N), .LAT(LAT)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  logic [31:0] x1_a [N];
  logic [31:0] x2_a [N];
  logic        op_a [N];

  for (genvar i = 0; i < N; i++) begin : g_drv
    assign bus.req_x1[32*i +: 32] = x1_a[i];
    assign bus.req_x2[32*i +: 32] = x2_a[i];
    assign bus.req_op[i]          = op_a[i];
  end

  function automatic real fp_to_real(input logic [31:0] b);
    real m;
    if (b[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    m = m * (2.0 ** (real'(int'(b[30:23])) - 127.0));
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] real_to_fp(input real r);
    logic [63:0] d;
    int          e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fp_sub(input logic [31:0] a, input logic [31:0] b);
    return real_to_fp(fp_to_real(a) - fp_to_real(b));
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    return real_to_fp(fp_to_real(a) + fp_to_real(b));
  endfunction

  // Shared subtract unit: two register stages, no reset, samples operands every edge.
  logic [31:0] u_s0;
  always @(posedge clk) begin
    u_s0       <= fp_sub(bus.unit_x1, bus.unit_x2);
    bus.unit_y <= u_s0;
  end

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          mdl_ptr = 0;
  bit          exp_v  [int];
  int          exp_id [int];
  logic [31:0] exp_y  [int];
  int          grants_q[$];
  int          resp_id_q[$];
  int          resp_cyc_q[$];
  logic [31:0] resp_y_q[$];
  int          last_grant_cyc;
  logic [31:0] last_ux2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int mdl_winner();
    int i;
    if (!rstn || !bus.issue_en) return -1;
    for (int k = 0; k < N; k++) begin
      i = (mdl_ptr + k) % N;
      if (bus.req_valid[i]) return i;
    end
    return -1;
  endfunction

  // One clock cycle: check combinational outputs and due responses, then book the grant.
  task automatic cycle();
    int          w;
    logic [31:0] ex1, ex2;
    @(negedge clk);
    w = mdl_winner();
    chk("req_ready", 32'(bus.req_ready), (w < 0) ? 32'd0 : (32'd1 << w));
    ex1 = (w < 0) ? 32'd0 : x1_a[w];
    ex2 = (w < 0) ? 32'd0 : {x2_a[w][31] ^ op_a[w], x2_a[w][30:0]};
    chk("unit_x1", bus.unit_x1, ex1);
    chk("unit_x2", bus.unit_x2, ex2);
    if (w >= 0) begin
      grants_q.push_back(w);
      last_grant_cyc = cyc;
      last_ux2       = bus.unit_x2;
    end
    if (exp_v.exists(cyc)) begin
      chk("resp_valid", 32'(bus.resp_valid), 32'd1 << exp_id[cyc]);
      chk("resp_id", 32'(bus.resp_id), 32'(exp_id[cyc]));
      chk("resp_y", bus.resp_y, exp_y[cyc]);
    end else begin
      chk("resp_valid_idle", 32'(bus.resp_valid), 32'd0);
    end
    if (bus.resp_valid != '0) begin
      resp_id_q.push_back(int'(bus.resp_id));
      resp_y_q.push_back(bus.resp_y);
      resp_cyc_q.push_back(cyc);
    end
    chk("busy", 32'(bus.busy), 32'(exp_v.exists(cyc) || exp_v.exists(cyc + 1)));
    @(posedge clk);
    if (rstn && w >= 0) begin
      exp_v[cyc+LAT]  = 1'b1;
      exp_id[cyc+LAT] = w;
      exp_y[cyc+LAT]  = op_a[w] ? fp_add(x1_a[w], x2_a[w]) : fp_sub(x1_a[w], x2_a[w]);
      mdl_ptr = (w + 1) % N;
    end
    cyc++;
    #1;
  endtask

  task automatic reset_pulse();
    rstn = 1'b0;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    mdl_ptr = 0;
    exp_v.delete(); exp_id.delete(); exp_y.delete();
    cycle();
    rstn = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [31:0] x1, input logic [31:0] x2, input logic op);
    x1_a[i] = x1; x2_a[i] = x2; op_a[i] = op;
  endtask

  task automatic clear_logs();
    grants_q.delete(); resp_id_q.delete(); resp_y_q.delete(); resp_cyc_q.delete();
  endtask

  initial begin
    for (int i = 0; i < N; i++) set_req(i, 32'd0, 32'd0, 1'b0);
    bus.issue_en  = 1'b1;
    bus.req_valid = '1;
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #1;
    chk("init_busy", 32'(bus.busy), 32'd0);
    chk("init_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("init_resp_id", 32'(bus.resp_id), 32'd0);
    chk("init_req_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    cycle();
    bus.req_valid = '0;
    rstn = 1'b1;

    // Single FSUB from requester 0
    clear_logs();
    set_req(0, 32'h3F800000, 32'h3F000000, 1'b0);
    bus.req_valid = 4'b0001;
    cycle();
    bus.req_valid = '0;
    repeat (3) cycle();
    chk("fsub_ux2", last_ux2, 32'h3F000000);
    chk("fsub_y", resp_y_q[$], 32'h3F000000);
    chk("fsub_id", 32'(resp_id_q[$]), 32'd0);
    chk("fsub_lat", 32'(resp_cyc_q[$] - last_grant_cyc), 32'(LAT));

    // Single FADD from requester 2
    clear_logs();
    set_req(2, 32'h3F800000, 32'h3F800000, 1'b1);
    bus.req_valid = 4'b0100;
    cycle();
    bus.req_valid = '0;
    repeat (3) cycle();
    chk("fadd_ux2", last_ux2, 32'hBF800000);
    chk("fadd_y", resp_y_q[$], 32'h40000000);
    chk("fadd_id", 32'(resp_id_q[$]), 32'd2);

    // Fairness from the reset pointer
    reset_pulse();
    clear_logs();
    for (int i = 0; i < N; i++) set_req(i, 32'h40000000 + 32'(i << 20), 32'h3F800000, 1'(i & 1));
    bus.req_valid = '1;
    repeat (8) cycle();
    bus.req_valid = '0;
    repeat (3) cycle();
    chk("fair_ngrant", 32'(grants_q.size()), 32'd8);
    chk("fair_nresp", 32'(resp_id_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("fair_grant", 32'(grants_q[i]), 32'(i % N));
      chk("fair_resp_id", 32'(resp_id_q[i]), 32'(i % N));
      if (i > 0) chk("fair_gap", 32'(resp_cyc_q[i] - resp_cyc_q[i-1]), 32'd1);
    end

    // issue_en low with ops in flight
    clear_logs();
    bus.req_valid = '1;
    repeat (2) cycle();
    bus.issue_en  = 1'b0;
    bus.req_valid = 4'b1010;
    repeat (3) cycle();
    chk("hold_busy", 32'(bus.busy), 32'd0);
    chk("hold_nresp", 32'(resp_id_q.size()), 32'd2);
    chk("hold_ngrant", 32'(grants_q.size()), 32'd2);
    bus.issue_en = 1'b1;
    cycle();
    chk("resume_grant", 32'(grants_q[$]), 32'd3);
    bus.req_valid = '0;
    repeat (3) cycle();

    // Reset with two ops in flight
    clear_logs();
    bus.req_valid = '1;
    repeat (2) cycle();
    bus.req_valid = '0;
    reset_pulse();
    repeat (LAT + 1) cycle();
    chk("rst_nresp", 32'(resp_id_q.size()), 32'd0);
    bus.req_valid = '1;
    cycle();
    chk("rst_ptr_grant", 32'(grants_q[$]), 32'd0);
    bus.req_valid = '0;
    repeat (3) cycle();

    // Back-to-back from requester 1
    clear_logs();
    bus.req_valid = 4'b0010;
    set_req(1, 32'h40400000, 32'h3F800000, 1'b0); cycle();
    set_req(1, 32'h40A00000, 32'h40000000, 1'b0); cycle();
    set_req(1, 32'h3F800000, 32'h3F800000, 1'b0); cycle();
    bus.req_valid = '0;
    repeat (3) cycle();
    chk("b2b_nresp", 32'(resp_y_q.size()), 32'd3);
    chk("b2b_y0", resp_y_q[0], 32'h40000000);
    chk("b2b_y1", resp_y_q[1], 32'h40400000);
    chk("b2b_y2", resp_y_q[2], 32'h00000000);
    chk("b2b_gap", 32'(resp_cyc_q[2] - resp_cyc_q[0]), 32'd2);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < N; i++)
        set_req(i, {1'($urandom), 8'($urandom_range(134, 120)), 23'($urandom)},
                   {1'($urandom), 8'($urandom_range(134, 120)), 23'($urandom)},
                   1'($urandom));
      bus.req_valid = N'($urandom);
      bus.issue_en  = ($urandom_range(9, 0) != 0);
      cycle();
    end
    bus.req_valid = '0;
    repeat (3) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
